// File: rtl/uart_rx_cmd_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the UART command frame controller.
package uart_rx_cmd_ctrl_pkg;

   localparam int         UART_DATA_LENGTH = 8;
   localparam int         UART_CMD_MAX_LEN = 16;
   localparam int         UART_CMD_TIMEOUT = 20000;
   localparam logic [7:0] UART_CMD_SYNC    = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LEN,
      ST_DATA,
      ST_CHK,
      ST_COMMIT
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Address/data write bus with ready/valid handshake driven by the frame controller.
interface uart_rx_cmd_ctrl_if #(
   parameter int DW = 8
);
   logic [DW-1:0] wr_addr_o;
   logic [DW-1:0] wr_data_o;
   logic          wr_v_o;
   logic          wr_rdy_i;

   modport master (output wr_addr_o, output wr_data_o, output wr_v_o, input wr_rdy_i);
   modport slave  (input wr_addr_o, input wr_data_o, input wr_v_o, output wr_rdy_i);
endinterface

// File: rtl/uart_rx_frame_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled and pulses expire at the terminal count.
module uart_rx_frame_timer #(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // A clear in the terminal cycle wins, so a late byte never trips the abort.
   always_comb begin
      cnt_d    = cnt_q;
      expire_o = 1'b0;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
         expire_o = 1'b1;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses SYNC/ADDR/LEN/payload/CHK write frames from uart_rx, buffers the payload and
// replays it onto the write bus only after the checksum verifies.
module uart_rx_cmd_ctrl
   import uart_rx_cmd_ctrl_pkg::*;
#(
   parameter int                     DATA_LENGTH    = UART_DATA_LENGTH,
   parameter int                     MAX_LEN        = UART_CMD_MAX_LEN,
   parameter int                     TIMEOUT_CYCLES = UART_CMD_TIMEOUT,
   parameter logic [DATA_LENGTH-1:0] SYNC_BYTE      = UART_CMD_SYNC
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic [DATA_LENGTH-1:0] rx_i,
   input  logic                   rx_v_i,
   uart_rx_cmd_ctrl_if.master     wr_if,
   output logic                   busy_o,
   output logic                   frame_ok_o,
   output logic                   frame_err_o,
   output logic [1:0]             err_code_o,
   output logic [7:0]             drop_cnt_o
);
   localparam int DW    = DATA_LENGTH;
   localparam int IDX_W = $clog2(MAX_LEN + 1);
   localparam int AW    = $clog2(MAX_LEN);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LEN     = 2'd1;
   localparam logic [1:0] ERR_CHK     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   state_e            state_q, state_d;
   logic [DW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     sum_q, sum_d;
   logic [IDX_W-1:0]  len_q, len_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              ok_q, ok_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic [7:0]        drop_q, drop_d;
   logic [DW-1:0]     buf_q [MAX_LEN];
   logic              buf_we;

   logic              timer_en, expire, commit;
   logic [IDX_W-1:0]  idx_inc;
   logic [DW-1:0]     sum_add;
   logic              len_bad;

   assign timer_en = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                     (state_q == ST_DATA) || (state_q == ST_CHK);
   assign commit   = (state_q == ST_COMMIT);
   assign idx_inc  = idx_q + IDX_W'(1);
   assign sum_add  = sum_q + rx_i;
   assign len_bad  = (rx_i == '0) || (rx_i > DW'(MAX_LEN));

   uart_rx_frame_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (rx_v_i),
      .en_i     (timer_en),
      .expire_o (expire)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         sum_q   <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         code_q  <= code_d;
         drop_q  <= drop_d;
      end
   end

   // Payload storage needs no reset: it is only read back after a full, verified frame.
   always_ff @(posedge clk_i) begin
      if (buf_we) buf_q[idx_q[AW-1:0]] <= rx_i;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (rx_v_i && rx_i == SYNC_BYTE) state_d = ST_ADDR;
         ST_ADDR:   if (rx_v_i) state_d = ST_LEN;
                    else if (expire) state_d = ST_IDLE;
         ST_LEN:    if (rx_v_i) state_d = len_bad ? ST_IDLE : ST_DATA;
                    else if (expire) state_d = ST_IDLE;
         ST_DATA:   if (rx_v_i) state_d = (idx_inc == len_q) ? ST_CHK : ST_DATA;
                    else if (expire) state_d = ST_IDLE;
         ST_CHK:    if (rx_v_i) state_d = (sum_add == '0) ? ST_COMMIT : ST_IDLE;
                    else if (expire) state_d = ST_IDLE;
         ST_COMMIT: if (wr_if.wr_rdy_i && idx_inc == len_q) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      sum_d  = sum_q;
      len_d  = len_q;
      idx_d  = idx_q;
      ok_d   = 1'b0;
      err_d  = 1'b0;
      code_d = code_q;
      drop_d = drop_q;
      buf_we = 1'b0;
      if (expire) begin
         err_d  = 1'b1;
         code_d = ERR_TIMEOUT;
      end
      unique case (state_q)
         ST_ADDR: if (rx_v_i) begin
            addr_d = rx_i;
            sum_d  = rx_i;
            idx_d  = '0;
         end
         ST_LEN: if (rx_v_i) begin
            if (len_bad) begin
               err_d  = 1'b1;
               code_d = ERR_LEN;
            end else begin
               len_d = IDX_W'(rx_i);
               sum_d = sum_add;
            end
         end
         ST_DATA: if (rx_v_i) begin
            buf_we = 1'b1;
            sum_d  = sum_add;
            idx_d  = idx_inc;
         end
         ST_CHK: if (rx_v_i) begin
            if (sum_add != '0) begin
               err_d  = 1'b1;
               code_d = ERR_CHK;
            end else begin
               idx_d = '0;
            end
         end
         ST_COMMIT: begin
            if (rx_v_i) drop_d = sat_inc8(drop_q);
            if (wr_if.wr_rdy_i) begin
               if (idx_inc == len_q) begin
                  ok_d   = 1'b1;
                  code_d = ERR_NONE;
                  idx_d  = '0;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         default: ;
      endcase
   end

   assign wr_if.wr_v_o    = commit;
   assign wr_if.wr_addr_o = commit ? addr_q + DW'(idx_q) : '0;
   assign wr_if.wr_data_o = commit ? buf_q[idx_q[AW-1:0]] : '0;
   assign busy_o          = (state_q != ST_IDLE);
   assign frame_ok_o      = ok_q;
   assign frame_err_o     = err_q;
   assign err_code_o      = code_q;
   assign drop_cnt_o      = drop_q;
endmodule
